// File: rtl/alu_arb_pkg.sv
// ----------------------------------------------------------------------------
// alu_arb_pkg
// Shared definitions for the ALU sharing arbiter:
//   - default operand/result and control widths
//   - ALU control code constants (passed through to the shared ALU unchanged)
//   - grant index encoding used by the round-robin last_grant register
// ----------------------------------------------------------------------------
package alu_arb_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int CTRL_W_DEF = 4;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0011;
  localparam logic [3:0] ALU_SLT   = 4'b0100;
  localparam logic [3:0] ALU_NOR   = 4'b0101;
  localparam logic [3:0] ALU_LUI   = 4'b0110;
  localparam logic [3:0] ALU_XOR   = 4'b0111;
  localparam logic [3:0] ALU_SLL   = 4'b1000;
  localparam logic [3:0] ALU_SRL   = 4'b1001;
  localparam logic [3:0] ALU_AUIPC = 4'b1010;
  localparam logic [3:0] ALU_SLTU  = 4'b1011;
  localparam logic [3:0] ALU_SRA   = 4'b1100;

  // Index of the requester that received the most recent grant.
  typedef enum logic {
    LAST0 = 1'b0,
    LAST1 = 1'b1
  } grant_idx_e;

endpackage

// File: rtl/alu_rsp_slot.sv
// ----------------------------------------------------------------------------
// alu_rsp_slot
// One-entry result buffer for one requester of the shared ALU.
//   clk        : system clock, rising edge
//   reset      : synchronous, active-high; clears valid and result
//   i_load     : capture i_data this edge (requester was granted this cycle)
//   i_drain    : consumer takes the buffered result this cycle (rspN_ready)
//   i_data     : ALU result to capture
//   o_valid    : buffered result is valid
//   o_result   : buffered result (holds its last value after a drain)
//   o_can_load : slot can take a new result this cycle (empty or draining)
// ----------------------------------------------------------------------------
module alu_rsp_slot
  import alu_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic              i_drain,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_result,
  output logic              o_can_load
);

  logic              r_valid;
  logic [DATA_W-1:0] r_result;

  // A full slot can still accept when the consumer drains it in the same
  // cycle, which is what gives a requester full throughput.
  assign o_can_load = ~r_valid | i_drain;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering. The result register
  // is reset too because its value is architecturally visible after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid  <= 1'b0;
      r_result <= '0;
    end else if (i_load) begin
      r_valid  <= 1'b1;
      r_result <= i_data;
    end else if (i_drain) begin
      r_valid  <= 1'b0;
    end
  end

  assign o_valid  = r_valid;
  assign o_result = r_result;

endmodule

// File: rtl/alu_share_arbiter.sv
// ----------------------------------------------------------------------------
// alu_share_arbiter
// Shares one combinational ALU between the execute stage (requester 0) and
// the address/auxiliary unit (requester 1). At most one operation issues per
// cycle; its result is captured into the requester's one-entry response slot
// at the end of the grant cycle.
//
// Ports:
//   clk, reset                 clock / synchronous active-high reset
//   reqN_valid/ready           request handshake (ready = grant, combinational)
//   reqN_ctrl/a/b              request ALU control and operands
//   rspN_valid/ready/result    response handshake and buffered result
//   alu_a/alu_b/alu_ctrl       drive to the shared ALU (idle when no grant)
//   alu_result                 combinational result from the shared ALU
//
// Build option: define ALU_ARB_FIXED_PRIO_EN to make requester 0 win every
// contention (no last_grant state; requester 1 may starve). Default build is
// round-robin.
// ----------------------------------------------------------------------------
module alu_share_arbiter
  import alu_arb_pkg::*;
#(
  parameter int                DATA_W    = DATA_W_DEF,
  parameter int                CTRL_W    = CTRL_W_DEF,
  parameter logic [CTRL_W-1:0] IDLE_CTRL = CTRL_W'(ALU_AND)
) (
  input  logic              clk,
  input  logic              reset,
  // requester 0
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [CTRL_W-1:0] req0_ctrl,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_result,
  // requester 1
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [CTRL_W-1:0] req1_ctrl,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_result,
  // shared ALU
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [CTRL_W-1:0] alu_ctrl,
  input  logic [DATA_W-1:0] alu_result
);

  logic w_can_load0, w_can_load1;
  logic w_elig0, w_elig1;
  logic w_grant0, w_grant1;

  assign w_elig0 = req0_valid & w_can_load0;
  assign w_elig1 = req1_valid & w_can_load1;

`ifdef ALU_ARB_FIXED_PRIO_EN
  // Fixed priority: requester 0 always wins.
  assign w_grant0 = w_elig0;
  assign w_grant1 = w_elig1 & ~w_elig0;
`else
  grant_idx_e r_last_grant;
  grant_idx_e w_last_grant_nxt;

  // Under contention the requester that was not granted last time wins.
  assign w_grant0 = w_elig0 & (~w_elig1 | (r_last_grant == LAST1));
  assign w_grant1 = w_elig1 & ~w_grant0;

  // Reset to LAST1 so requester 0 wins the first contention.
  always_ff @(posedge clk) begin
    if (reset) r_last_grant <= LAST1;
    else       r_last_grant <= w_last_grant_nxt;
  end

  // NOTE: every signal written in always_comb gets a default first so no
  // path through the block leaves it unassigned (which would infer a latch).
  always_comb begin
    w_last_grant_nxt = r_last_grant;
    if (w_grant0)      w_last_grant_nxt = LAST0;
    else if (w_grant1) w_last_grant_nxt = LAST1;
  end
`endif

  assign req0_ready = w_grant0;
  assign req1_ready = w_grant1;

  always_comb begin
    alu_a    = '0;
    alu_b    = '0;
    alu_ctrl = IDLE_CTRL;
    if (w_grant0) begin
      alu_a    = req0_a;
      alu_b    = req0_b;
      alu_ctrl = req0_ctrl;
    end else if (w_grant1) begin
      alu_a    = req1_a;
      alu_b    = req1_b;
      alu_ctrl = req1_ctrl;
    end
  end

  alu_rsp_slot #(.DATA_W(DATA_W)) u_slot0 (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_grant0),
    .i_drain    (rsp0_ready),
    .i_data     (alu_result),
    .o_valid    (rsp0_valid),
    .o_result   (rsp0_result),
    .o_can_load (w_can_load0)
  );

  alu_rsp_slot #(.DATA_W(DATA_W)) u_slot1 (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_grant1),
    .i_drain    (rsp1_ready),
    .i_data     (alu_result),
    .o_valid    (rsp1_valid),
    .o_result   (rsp1_result),
    .o_can_load (w_can_load1)
  );

endmodule

// File: tb/tb_alu_share_arbiter.sv
// ----------------------------------------------------------------------------
// tb_alu_share_arbiter
// Directed bench for alu_share_arbiter. A small combinational ALU model sits
// on the shared ALU port; expected values are written out by hand.
// Inputs change at the falling edge; outputs are checked 1 ns later.
// ----------------------------------------------------------------------------
module tb_alu_share_arbiter;
  import alu_arb_pkg::*;

`ifdef ALU_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, rsp0_valid, rsp0_ready;
  logic [3:0]  req0_ctrl;
  logic [31:0] req0_a, req0_b, rsp0_result;
  logic        req1_valid, req1_ready, rsp1_valid, rsp1_ready;
  logic [3:0]  req1_ctrl;
  logic [31:0] req1_a, req1_b, rsp1_result;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [3:0]  alu_ctrl;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_model(input logic [3:0] c,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    case (c)
      ALU_AND:   return a & b;
      ALU_OR:    return a | b;
      ALU_ADD:   return a + b;
      ALU_SUB:   return a - b;
      ALU_SLT:   return {31'b0, $signed(a) < $signed(b)};
      ALU_NOR:   return ~(a | b);
      ALU_LUI:   return b;
      ALU_XOR:   return a ^ b;
      ALU_SLL:   return a << b[4:0];
      ALU_SRL:   return a >> b[4:0];
      ALU_AUIPC: return a + b;
      ALU_SLTU:  return {31'b0, a < b};
      ALU_SRA:   return 32'($signed(a) >>> b[4:0]);
      default:   return 32'h0;
    endcase
  endfunction

  assign alu_result = alu_model(alu_ctrl, alu_a, alu_b);

  alu_share_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_ctrl   (req0_ctrl),
    .req0_a      (req0_a),
    .req0_b      (req0_b),
    .rsp0_valid  (rsp0_valid),
    .rsp0_ready  (rsp0_ready),
    .rsp0_result (rsp0_result),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_ctrl   (req1_ctrl),
    .req1_a      (req1_a),
    .req1_b      (req1_b),
    .rsp1_valid  (rsp1_valid),
    .rsp1_ready  (rsp1_ready),
    .rsp1_result (rsp1_result),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_ctrl    (alu_ctrl),
    .alu_result  (alu_result)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one full cycle: through the rising edge to the next falling edge.
  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    bit prev0, prev1;
    reset = 1'b1;
    req0_valid = 1'b0; req0_ctrl = '0; req0_a = '0; req0_b = '0; rsp0_ready = 1'b0;
    req1_valid = 1'b0; req1_ctrl = '0; req1_a = '0; req1_b = '0; rsp1_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;

    // Reset then idle
    chk("rst_rsp0_valid",  rsp0_valid,  0);
    chk("rst_rsp1_valid",  rsp1_valid,  0);
    chk("rst_rsp0_result", rsp0_result, 0);
    chk("rst_rsp1_result", rsp1_result, 0);
    chk("idle_alu_ctrl",   alu_ctrl,    4'b0000);
    chk("idle_alu_a",      alu_a,       0);
    chk("idle_alu_b",      alu_b,       0);

    // Requester 0 alone: ADD 5,7
    @(negedge clk);
    req0_valid = 1'b1; req0_ctrl = ALU_ADD; req0_a = 32'd5; req0_b = 32'd7;
    rsp0_ready = 1'b1;
    #1;
    chk("add_req0_ready", req0_ready, 1);
    chk("add_req1_ready", req1_ready, 0);
    chk("add_alu_a",      alu_a,      5);
    chk("add_alu_b",      alu_b,      7);
    chk("add_alu_ctrl",   alu_ctrl,   ALU_ADD);
    next_cycle();
    req0_valid = 1'b0;
    #1;
    chk("add_rsp0_valid",  rsp0_valid,  1);
    chk("add_rsp0_result", rsp0_result, 12);
    next_cycle();
    #1;
    chk("drain_rsp0_valid",  rsp0_valid,  0);
    chk("drain_rsp0_result", rsp0_result, 12);

    // Fresh reset so last_grant starts at its reset value, then contention
    @(negedge clk);
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    req0_valid = 1'b1; req0_ctrl = ALU_SUB; req0_a = 32'd10;         req0_b = 32'd3;
    req1_valid = 1'b1; req1_ctrl = ALU_SRA; req1_a = 32'h8000_0000; req1_b = 32'd4;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    prev0 = 1'b0; prev1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bit g0;
      g0 = FIXED || (i % 2 == 0);
      #1;
      chk("rr_req0_ready", req0_ready, g0);
      chk("rr_req1_ready", req1_ready, !g0);
      chk("rr_rsp0_valid", rsp0_valid, prev0);
      chk("rr_rsp1_valid", rsp1_valid, prev1);
      if (prev0) chk("rr_rsp0_result", rsp0_result, 32'd7);
      if (prev1) chk("rr_rsp1_result", rsp1_result, 32'hF800_0000);
      prev0 = g0;
      prev1 = !g0;
      next_cycle();
    end

    // Idle cycle: drop requests, let both slots drain
    req0_valid = 1'b0; req1_valid = 1'b0;
    next_cycle();

    // Requester 1 gets one result, then its consumer stalls
    req1_valid = 1'b1; rsp1_ready = 1'b0;
    #1;
    chk("stall_first_req1_ready", req1_ready, 1);
    next_cycle();
    req0_valid = 1'b1; req0_ctrl = ALU_ADD; req0_a = 32'd1; req0_b = 32'd1;
    rsp0_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("stall_req0_ready",   req0_ready,  1);
      chk("stall_req1_ready",   req1_ready,  0);
      chk("stall_rsp1_valid",   rsp1_valid,  1);
      chk("stall_rsp1_result",  rsp1_result, 32'hF800_0000);
      chk("stall_rsp0_valid",   rsp0_valid,  (i > 0));
      if (i > 0) chk("stall_rsp0_result", rsp0_result, 32'd2);
      next_cycle();
    end

    // Slot 1 drain-and-refill; slot 0 left full (result 2)
    req0_valid = 1'b0; rsp0_ready = 1'b0; rsp1_ready = 1'b1;
    #1;
    chk("refill_req1_ready", req1_ready, 1);
    chk("refill_rsp0_valid", rsp0_valid, 1);
    next_cycle();

    // Slot 0 full plus drain in the same cycle: SLTU 1,0xFFFFFFFF
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_ctrl = ALU_SLTU; req0_a = 32'd1; req0_b = 32'hFFFF_FFFF;
    rsp0_ready = 1'b1;
    #1;
    chk("sltu_req0_ready",   req0_ready,  1);
    chk("sltu_rsp0_valid",   rsp0_valid,  1);
    chk("sltu_rsp0_old",     rsp0_result, 32'd2);
    chk("refill_rsp1_valid", rsp1_valid,  1);
    chk("refill_rsp1_result", rsp1_result, 32'hF800_0000);
    next_cycle();

    // Keep slot 0 full, fill slot 1 again
    req0_valid = 1'b0; rsp0_ready = 1'b0;
    req1_valid = 1'b1; rsp1_ready = 1'b0;
    #1;
    chk("sltu_rsp0_valid_next",  rsp0_valid,  1);
    chk("sltu_rsp0_result_next", rsp0_result, 32'd1);
    chk("fill1_req1_ready",      req1_ready,  1);
    next_cycle();

    // Both slots full, both requests pending, reset asserted
    req0_valid = 1'b1; req0_ctrl = ALU_ADD; req0_a = 32'd5; req0_b = 32'd7;
    reset = 1'b1;
    #1;
    chk("full_req0_ready", req0_ready, 0);
    chk("full_req1_ready", req1_ready, 0);
    chk("full_rsp1_valid", rsp1_valid, 1);
    chk("full_alu_ctrl",   alu_ctrl,   4'b0000);
    next_cycle();
    reset = 1'b0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    #1;
    chk("postrst_rsp0_valid",  rsp0_valid,  0);
    chk("postrst_rsp1_valid",  rsp1_valid,  0);
    chk("postrst_rsp0_result", rsp0_result, 0);
    chk("postrst_rsp1_result", rsp1_result, 0);
    chk("postrst_req0_ready",  req0_ready,  1);
    chk("postrst_req1_ready",  req1_ready,  0);
    next_cycle();
    #1;
    chk("postrst2_req0_ready",  req0_ready,  FIXED ? 1 : 0);
    chk("postrst2_req1_ready",  req1_ready,  FIXED ? 0 : 1);
    chk("postrst2_rsp0_valid",  rsp0_valid,  1);
    chk("postrst2_rsp0_result", rsp0_result, 32'd12);
    next_cycle();
    #1;
    chk("postrst3_req0_ready", req0_ready, 1);
    chk("postrst3_req1_ready", req1_ready, 0);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
